dp_ram_clr: RTL and testbench

DP_RAM_CLR -- requirements
Module: dp_ram_clr

---
 rtl/dp_ram_clr.sv | 144 ++++++++++++++
 tb/tb_dp_ram_clr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_clr.sv
// Dual-port RAM with byte enables, a self-clearing sweep after reset or on request,
// and a 1- or 2-cycle read pipeline that flags out-of-range reads.
//
// state    | meaning
// ST_CLEAR | sweep writes zero to word cnt_q each cycle; ports ignored; busy_o high
// ST_READY | normal read/write operation; clr_i restarts the sweep at word 0
module dp_ram_clr #(
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WORDS  = 256,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0,
   localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   output logic                  busy_o,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [BE_WIDTH-1:0]   be_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  rerr_o
);

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_READY = 1'b1;

   // One extra bit so NUM_WORDS == 2**ADDR_WIDTH is representable in the range compare.
   localparam logic [ADDR_WIDTH:0]   NUM_W     = (ADDR_WIDTH+1)'(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   logic                  state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic                  ready;
   logic                  wr_ok;
   logic                  rd_go;
   logic                  rd_in_range;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  v1_q;
   logic                  e1_q;
   logic [DATA_WIDTH-1:0] d1_q;

   assign ready       = (state_q == ST_READY);
   assign busy_o      = ~ready;
   assign wr_ok       = ready & we_i & ({1'b0, waddr_i} < NUM_W);
   assign rd_in_range = ({1'b0, raddr_i} < NUM_W);
   assign rd_go       = ready & re_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_READY;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               if (clr_i) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   // Array has no reset; it is zeroed only by the sweep.
   always_ff @(posedge clk) begin
      if (!ready) begin
         mem[cnt_q] <= '0;
      end else if (wr_ok) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (be_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Write-first merge for a same-cycle read and write to one address.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[raddr_i];
         if (wr_ok && (waddr_i == raddr_i)) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
               if (be_i[b]) rd_word[8*b +: 8] = wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         e1_q <= 1'b0;
         d1_q <= '0;
      end else begin
         v1_q <= rd_go;
         e1_q <= rd_go & ~rd_in_range;
         if (rd_go) d1_q <= rd_word;
      end
   end

   generate
      if (OUT_REG == 0) begin : g_direct
         assign rvalid_o = v1_q;
         assign rerr_o   = e1_q;
         assign rdata_o  = d1_q;
      end else begin : g_outreg
         logic                  v2_q;
         logic                  e2_q;
         logic [DATA_WIDTH-1:0] d2_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v2_q <= 1'b0;
               e2_q <= 1'b0;
               d2_q <= '0;
            end else begin
               v2_q <= v1_q;
               e2_q <= e1_q;
               if (v1_q) d2_q <= d1_q;
            end
         end

         assign rvalid_o = v2_q;
         assign rerr_o   = e2_q;
         assign rdata_o  = d2_q;
      end
   endgenerate

endmodule

// File: tb/tb_dp_ram_clr.sv
// Bench for dp_ram_clr: a 256-word OUT_REG=0 instance and a 200-word OUT_REG=1
// instance share stimulus and are compared every cycle against a word-array model.
module tb_dp_ram_clr;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        we;
   logic        re;
   logic [7:0]  waddr;
   logic [7:0]  raddr;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic        busy0, rvalid0, rerr0;
   logic [31:0] rdata0;
   logic        busy1, rvalid1, rerr1;
   logic [31:0] rdata1;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: word arrays, remaining clear cycles, and responses keyed by due cycle.
   logic [31:0] mm    [2][256];
   int          left  [2];
   logic [31:0] lastd [2];
   bit          sv    [2][4096];
   logic [31:0] sd    [2][4096];
   bit          se    [2][4096];

   dp_ram_clr #(.ADDR_WIDTH(8), .NUM_WORDS(256), .DATA_WIDTH(32), .OUT_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy0),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .be_i(be),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata0), .rvalid_o(rvalid0), .rerr_o(rerr0)
   );

   dp_ram_clr #(.ADDR_WIDTH(8), .NUM_WORDS(200), .DATA_WIDTH(32), .OUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .busy_o(busy1),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .be_i(be),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata1), .rvalid_o(rvalid1), .rerr_o(rerr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] en);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         left[k]  = (k == 0) ? 256 : 200;
         lastd[k] = '0;
         for (int i = 0; i < 256; i++) mm[k][i] = '0;
         for (int s = 0; s < 4096; s++) sv[k][s] = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int n;
         int lat;
         int slot;
         n   = (k == 0) ? 256 : 200;
         lat = (k == 0) ? 1 : 2;
         if (left[k] == 0) begin
            if (we && int'(waddr) < n) mm[k][waddr] = merge(mm[k][waddr], wdata, be);
            if (re) begin
               slot = (cyc + lat - 1) % 4096;
               sv[k][slot] = 1'b1;
               if (int'(raddr) >= n) begin
                  sd[k][slot] = '0;
                  se[k][slot] = 1'b1;
               end else begin
                  sd[k][slot] = mm[k][raddr];
                  se[k][slot] = 1'b0;
               end
            end
            if (clr) begin
               left[k] = n;
               for (int i = 0; i < 256; i++) mm[k][i] = '0;
            end
         end else begin
            left[k]--;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         int          slot;
         bit          ev;
         logic [31:0] ed;
         bit          ee;
         slot = cyc % 4096;
         ev   = sv[k][slot];
         ed   = ev ? sd[k][slot] : lastd[k];
         ee   = ev ? se[k][slot] : 1'b0;
         if (ev) lastd[k] = sd[k][slot];
         sv[k][slot] = 1'b0;
         chk($sformatf("busy%0d", k),   (k == 0) ? busy0   : busy1,   (left[k] != 0));
         chk($sformatf("rvalid%0d", k), (k == 0) ? rvalid0 : rvalid1, ev);
         chk($sformatf("rerr%0d", k),   (k == 0) ? rerr0   : rerr1,   ee);
         chk($sformatf("rdata%0d", k),  (k == 0) ? rdata0  : rdata1,  ed);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst_n) model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      clr = 1'b0; we = 1'b0; re = 1'b0;
      waddr = '0; raddr = '0; wdata = '0; be = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy0"}, busy0, 1'b1);
      chk({tag, "_rvalid0"}, rvalid0, 1'b0);
      chk({tag, "_rerr0"}, rerr0, 1'b0);
      chk({tag, "_rdata0"}, rdata0, 32'h0);
      chk({tag, "_busy1"}, busy1, 1'b1);
      chk({tag, "_rvalid1"}, rvalid1, 1'b0);
      chk({tag, "_rerr1"}, rerr1, 1'b0);
      chk({tag, "_rdata1"}, rdata1, 32'h0);
   endtask

   task automatic read_all();
      for (int i = 0; i < 256; i++) begin
         idle(); re = 1'b1; raddr = 8'(i);
         tick();
      end
      idle();
      repeat (3) tick();
   endtask

   task automatic fill_all();
      for (int i = 0; i < 256; i++) begin
         idle(); we = 1'b1; waddr = 8'(i); wdata = $urandom; be = 4'hF;
         tick();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("por");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      repeat (260) tick();
      read_all();

      // Byte-enable merge
      we = 1'b1; waddr = 8'h10; wdata = 32'hAABBCCDD; be = 4'b1111; tick();
      we = 1'b1; waddr = 8'h10; wdata = 32'h11223344; be = 4'b0101; tick();
      idle(); re = 1'b1; raddr = 8'h10; tick();
      idle();
      chk("be_merge_v0", rvalid0, 1'b1);
      chk("be_merge_d0", rdata0, 32'hAA22CC44);
      tick();
      chk("be_merge_v1", rvalid1, 1'b1);
      chk("be_merge_d1", rdata1, 32'hAA22CC44);
      tick();

      // Same-cycle write-first
      we = 1'b1; waddr = 8'h20; wdata = 32'hFFFFFFFF; be = 4'b0011;
      re = 1'b1; raddr = 8'h20;
      tick();
      idle();
      chk("wfirst_d0", rdata0, 32'h0000FFFF);
      tick();
      chk("wfirst_d1", rdata1, 32'h0000FFFF);
      tick();

      // Out-of-range address on the 200-word instance
      we = 1'b1; waddr = 8'hF0; wdata = 32'h12345678; be = 4'hF; tick();
      idle(); re = 1'b1; raddr = 8'hF0; tick();
      idle();
      chk("oor_d0", rdata0, 32'h12345678);
      chk("oor_e0", rerr0, 1'b0);
      tick();
      chk("oor_v1", rvalid1, 1'b1);
      chk("oor_e1", rerr1, 1'b1);
      chk("oor_d1", rdata1, 32'h0);
      tick();

      // Clear with a read accepted alongside the request, traffic ignored while busy
      fill_all();
      clr = 1'b1; re = 1'b1; raddr = 8'h05; tick();
      for (int i = 0; i < 50; i++) begin
         idle();
         we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
         waddr = 8'($urandom_range(0, 255)); raddr = 8'($urandom_range(0, 255));
         wdata = $urandom; be = 4'($urandom_range(0, 15));
         clr = 1'($urandom_range(0, 3) == 0);
         tick();
      end
      idle();
      repeat (210) tick();
      read_all();

      // Random traffic with occasional clears
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
         waddr = 8'($urandom_range(0, 255)); raddr = 8'($urandom_range(0, 255));
         wdata = $urandom; be = 4'($urandom_range(0, 15));
         clr = 1'($urandom_range(0, 79) == 0);
         tick();
      end
      idle();
      repeat (260) tick();

      // Reset in the middle of a sweep
      fill_all();
      clr = 1'b1; tick();
      idle();
      repeat (100) tick();
      rst_n = 1'b0;
      #1 check_reset_outputs("midsweep");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (260) tick();
      read_all();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
